// File: rtl/fullsend_pkg.sv
// Shared types for the fullsend 5-stage core: control bundle, opcodes, ALU and write-back selects.
package fullsend_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Branches carry {1'b1, funct3} in alu_op; EX disambiguates using ctrl.branch.
   typedef enum logic [3:0] {
      ALU_ADD   = 4'h0,
      ALU_SLL   = 4'h1,
      ALU_SLT   = 4'h2,
      ALU_SLTU  = 4'h3,
      ALU_XOR   = 4'h4,
      ALU_SRL   = 4'h5,
      ALU_OR    = 4'h6,
      ALU_AND   = 4'h7,
      ALU_SUB   = 4'h8,
      ALU_SRA   = 4'hD,
      ALU_PASSB = 4'hF
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       alu_src_imm;
      logic [3:0] alu_op;
      wb_sel_e    wb_sel;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{
      reg_write:   1'b0,
      mem_read:    1'b0,
      mem_write:   1'b0,
      branch:      1'b0,
      jump:        1'b0,
      alu_src_imm: 1'b0,
      alu_op:      4'h0,
      wb_sel:      WB_ALU
   };

   function automatic logic opc_known(input logic [6:0] opc);
      return (opc == OPC_LUI)    || (opc == OPC_AUIPC) || (opc == OPC_JAL)   ||
             (opc == OPC_JALR)   || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
             (opc == OPC_STORE)  || (opc == OPC_OPIMM) || (opc == OPC_OP);
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two async read ports, one sync write port, x0 hardwired to zero.
module regfile_2r1w #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   localparam int unsigned AW   = $clog2(NREGS)
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [AW-1:0]   i_raddr_a,
   input  logic [AW-1:0]   i_raddr_b,
   output logic [XLEN-1:0] o_rdata_a,
   output logic [XLEN-1:0] o_rdata_b
);

   logic [XLEN-1:0] r_mem [NREGS];

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Same-cycle write data wins so ID sees the value WB is committing now.
   always_comb begin
      o_rdata_a = r_mem[i_raddr_a];
      if (i_raddr_a == '0) begin
         o_rdata_a = '0;
      end else if (i_we && (i_waddr == i_raddr_a)) begin
         o_rdata_a = i_wdata;
      end
   end

   always_comb begin
      o_rdata_b = r_mem[i_raddr_b];
      if (i_raddr_b == '0) begin
         o_rdata_b = '0;
      end else if (i_we && (i_waddr == i_raddr_b)) begin
         o_rdata_b = i_wdata;
      end
   end

endmodule

// File: rtl/stage2_decode.sv
// ID stage: decodes IF/ID, reads the register file, detects load-use hazards and
// registers the ID/EX bundle, inserting bubbles on stall, flush and illegal opcodes.
module stage2_decode
   import fullsend_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [1:0][XLEN-1:0] i_if_id,
   input  logic                 i_branch_cond,
   input  logic                 i_wb_en,
   input  logic [4:0]           i_wb_rd,
   input  logic [XLEN-1:0]      i_wb_data,
   output logic                 o_hazard,
   output ctrl_t                o_id_ex_ctrl,
   output logic [XLEN-1:0]      o_id_ex_npc,
   output logic [XLEN-1:0]      o_id_ex_a,
   output logic [XLEN-1:0]      o_id_ex_b,
   output logic [XLEN-1:0]      o_id_ex_imm,
   output logic [4:0]           o_id_ex_rd,
   output logic [4:0]           o_id_ex_rs1,
   output logic [4:0]           o_id_ex_rs2,
   output logic                 o_illegal
);

   logic [31:0]     w_inst;
   logic [XLEN-1:0] w_npc;
   logic [6:0]      w_opc;
   logic [2:0]      w_f3;
   logic [4:0]      w_rd;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;

   assign w_inst = i_if_id[0][31:0];
   assign w_npc  = i_if_id[1];
   assign w_opc  = w_inst[6:0];
   assign w_f3   = w_inst[14:12];
   assign w_rd   = w_inst[11:7];
   assign w_rs1  = w_inst[19:15];
   assign w_rs2  = w_inst[24:20];

   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_s;
   logic [XLEN-1:0] w_imm_b;
   logic [XLEN-1:0] w_imm_u;
   logic [XLEN-1:0] w_imm_j;

   assign w_imm_i = {{(XLEN-12){w_inst[31]}}, w_inst[31:20]};
   assign w_imm_s = {{(XLEN-12){w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
   assign w_imm_b = {{(XLEN-12){w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
   assign w_imm_u = {{(XLEN-31){w_inst[31]}}, w_inst[30:12], 12'h000};
   assign w_imm_j = {{(XLEN-20){w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

   ctrl_t           w_ctrl;
   logic [XLEN-1:0] w_imm;
   logic            w_known;
   logic            w_rs1_used;
   logic            w_rs2_used;

   always_comb begin
      w_ctrl     = CTRL_NOP;
      w_imm      = '0;
      w_known    = opc_known(w_opc);
      w_rs1_used = 1'b0;
      w_rs2_used = 1'b0;
      case (w_opc)
         OPC_LUI: begin
            w_ctrl.reg_write   = 1'b1;
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.alu_op      = ALU_PASSB;
            w_imm              = w_imm_u;
         end
         OPC_AUIPC: begin
            w_ctrl.reg_write   = 1'b1;
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.alu_op      = ALU_ADD;
            w_imm              = w_imm_u;
         end
         OPC_JAL: begin
            w_ctrl.reg_write   = 1'b1;
            w_ctrl.jump        = 1'b1;
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.alu_op      = ALU_ADD;
            w_ctrl.wb_sel      = WB_PC4;
            w_imm              = w_imm_j;
         end
         OPC_JALR: begin
            w_ctrl.reg_write   = 1'b1;
            w_ctrl.jump        = 1'b1;
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.alu_op      = ALU_ADD;
            w_ctrl.wb_sel      = WB_PC4;
            w_imm              = w_imm_i;
            w_rs1_used         = 1'b1;
         end
         OPC_BRANCH: begin
            w_ctrl.branch = 1'b1;
            w_ctrl.alu_op = {1'b1, w_f3};
            w_imm         = w_imm_b;
            w_rs1_used    = 1'b1;
            w_rs2_used    = 1'b1;
         end
         OPC_LOAD: begin
            w_ctrl.reg_write   = 1'b1;
            w_ctrl.mem_read    = 1'b1;
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.alu_op      = ALU_ADD;
            w_ctrl.wb_sel      = WB_MEM;
            w_imm              = w_imm_i;
            w_rs1_used         = 1'b1;
         end
         OPC_STORE: begin
            w_ctrl.mem_write   = 1'b1;
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.alu_op      = ALU_ADD;
            w_imm              = w_imm_s;
            w_rs1_used         = 1'b1;
            w_rs2_used         = 1'b1;
         end
         OPC_OPIMM: begin
            // Only SRAI uses inst[30]; for other I-type ops it is immediate data.
            w_ctrl.reg_write   = 1'b1;
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.alu_op      = {w_inst[30] && (w_f3 == 3'b101), w_f3};
            w_imm              = w_imm_i;
            w_rs1_used         = 1'b1;
         end
         OPC_OP: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_op    = {w_inst[30] && ((w_f3 == 3'b000) || (w_f3 == 3'b101)), w_f3};
            w_rs1_used       = 1'b1;
            w_rs2_used       = 1'b1;
         end
         default: ;
      endcase
   end

   logic [XLEN-1:0] w_rdata_a;
   logic [XLEN-1:0] w_rdata_b;

   regfile_2r1w #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_regfile (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_we      (i_wb_en),
      .i_waddr   (i_wb_rd),
      .i_wdata   (i_wb_data),
      .i_raddr_a (w_rs1),
      .i_raddr_b (w_rs2),
      .o_rdata_a (w_rdata_a),
      .o_rdata_b (w_rdata_b)
   );

   ctrl_t           r_ctrl;
   logic [XLEN-1:0] r_npc;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic [XLEN-1:0] r_imm;
   logic [4:0]      r_rd;
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;
   logic            r_illegal;

   logic w_load_use;
   logic w_bubble;
   logic w_illegal;

   assign w_load_use = r_ctrl.mem_read && (r_rd != 5'd0) &&
                       ((w_rs1_used && (r_rd == w_rs1)) || (w_rs2_used && (r_rd == w_rs2)));
   assign o_hazard   = w_load_use && !i_branch_cond;
   // An all-zero word has an unknown opcode, so it bubbles here without flagging illegal.
   assign w_bubble   = i_branch_cond || w_load_use || !w_known;
   assign w_illegal  = !i_branch_cond && !w_known && (w_inst != 32'h0);

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_ctrl    <= CTRL_NOP;
         r_npc     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_imm     <= '0;
         r_rd      <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= w_illegal;
         if (w_bubble) begin
            r_ctrl <= CTRL_NOP;
            r_npc  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_imm  <= '0;
            r_rd   <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
         end else begin
            r_ctrl <= w_ctrl;
            r_npc  <= w_npc;
            r_a    <= w_rdata_a;
            r_b    <= w_rdata_b;
            r_imm  <= w_imm;
            r_rd   <= w_rd;
            r_rs1  <= w_rs1;
            r_rs2  <= w_rs2;
         end
      end
   end

   assign o_id_ex_ctrl = r_ctrl;
   assign o_id_ex_npc  = r_npc;
   assign o_id_ex_a    = r_a;
   assign o_id_ex_b    = r_b;
   assign o_id_ex_imm  = r_imm;
   assign o_id_ex_rd   = r_rd;
   assign o_id_ex_rs1  = r_rs1;
   assign o_id_ex_rs2  = r_rs2;
   assign o_illegal    = r_illegal;

endmodule

// File: tb/tb_stage2_decode.sv
// Bench for stage2_decode: directed scenarios then random traffic against a behavioural model.
module tb_stage2_decode;
   import fullsend_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic [1:0][31:0] if_id;
   logic            branch_cond;
   logic            wb_en;
   logic [4:0]      wb_rd;
   logic [31:0]     wb_data;
   logic            hazard;
   ctrl_t           id_ex_ctrl;
   logic [31:0]     id_ex_npc, id_ex_a, id_ex_b, id_ex_imm;
   logic [4:0]      id_ex_rd, id_ex_rs1, id_ex_rs2;
   logic            illegal;

   stage2_decode #(
      .XLEN  (32),
      .NREGS (32)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_if_id       (if_id),
      .i_branch_cond (branch_cond),
      .i_wb_en       (wb_en),
      .i_wb_rd       (wb_rd),
      .i_wb_data     (wb_data),
      .o_hazard      (hazard),
      .o_id_ex_ctrl  (id_ex_ctrl),
      .o_id_ex_npc   (id_ex_npc),
      .o_id_ex_a     (id_ex_a),
      .o_id_ex_b     (id_ex_b),
      .o_id_ex_imm   (id_ex_imm),
      .o_id_ex_rd    (id_ex_rd),
      .o_id_ex_rs1   (id_ex_rs1),
      .o_id_ex_rs2   (id_ex_rs2),
      .o_illegal     (illegal)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [31:0] m_regs [32];
   ctrl_t       m_ctrl;
   logic [31:0] m_npc, m_a, m_b, m_imm;
   logic [4:0]  m_rd, m_rs1, m_rs2;
   logic        m_illegal;
   logic        m_haz;
   logic        s_haz;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
      logic signed [31:0] t;
      t = v << (32 - bits);
      return t >>> (32 - bits);
   endfunction

   task automatic ref_decode(input logic [31:0] inst, output logic known, output ctrl_t c,
                             output logic [31:0] imm, output logic u1, output logic u2);
      logic [2:0] f3;
      f3 = inst[14:12];
      c = CTRL_NOP; known = 1'b1; imm = 32'h0; u1 = 1'b1; u2 = 1'b0;
      case (inst[6:0])
         7'h37: begin c.reg_write = 1; c.alu_src_imm = 1; c.alu_op = 4'hF;
                      imm = inst & 32'hFFFF_F000; u1 = 0; end
         7'h17: begin c.reg_write = 1; c.alu_src_imm = 1; imm = inst & 32'hFFFF_F000; u1 = 0; end
         7'h6F: begin c.reg_write = 1; c.jump = 1; c.alu_src_imm = 1; c.wb_sel = WB_PC4; u1 = 0;
                      imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21); end
         7'h67: begin c.reg_write = 1; c.jump = 1; c.alu_src_imm = 1; c.wb_sel = WB_PC4;
                      imm = sext(inst >> 20, 12); end
         7'h63: begin c.branch = 1; c.alu_op = {1'b1, f3}; u2 = 1;
                      imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13); end
         7'h03: begin c.reg_write = 1; c.mem_read = 1; c.alu_src_imm = 1; c.wb_sel = WB_MEM;
                      imm = sext(inst >> 20, 12); end
         7'h23: begin c.mem_write = 1; c.alu_src_imm = 1; u2 = 1;
                      imm = sext({inst[31:25], inst[11:7]}, 12); end
         7'h13: begin c.reg_write = 1; c.alu_src_imm = 1; imm = sext(inst >> 20, 12);
                      c.alu_op = (f3 == 3'd5) ? {inst[30], f3} : {1'b0, f3}; end
         7'h33: begin c.reg_write = 1; u2 = 1;
                      c.alu_op = (f3 == 3'd0 || f3 == 3'd5) ? {inst[30], f3} : {1'b0, f3}; end
         default: begin known = 1'b0; u1 = 1'b0; end
      endcase
   endtask

   function automatic logic [31:0] rd_val(input logic [4:0] r);
      if (r == 5'd0) return 32'h0;
      if (wb_en && wb_rd == r) return wb_data;
      return m_regs[r];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_ctrl = CTRL_NOP; m_npc = 0; m_a = 0; m_b = 0; m_imm = 0;
      m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_illegal = 0; m_haz = 0;
   endtask

   // Called at posedge+1 with inputs applied; ends at the next posedge+1.
   task automatic step();
      logic [31:0] inst, imm;
      ctrl_t c;
      logic known, u1, u2, haz;
      logic [4:0] rs1, rs2;
      inst = if_id[0];
      ref_decode(inst, known, c, imm, u1, u2);
      rs1 = inst[19:15];
      rs2 = inst[24:20];
      haz = !branch_cond && m_ctrl.mem_read && (m_rd != 0) &&
            ((u1 && m_rd == rs1) || (u2 && m_rd == rs2));
      @(negedge clk);
      s_haz = hazard;
      check_eq("hazard", hazard, haz);
      m_haz = haz;
      if (!reset) begin
         model_reset();
      end else begin
         m_illegal = !branch_cond && !known && (inst != 0);
         if (branch_cond || haz || !known) begin
            m_ctrl = CTRL_NOP; m_npc = 0; m_a = 0; m_b = 0; m_imm = 0;
            m_rd = 0; m_rs1 = 0; m_rs2 = 0;
         end else begin
            m_ctrl = c; m_npc = if_id[1]; m_a = rd_val(rs1); m_b = rd_val(rs2); m_imm = imm;
            m_rd = inst[11:7]; m_rs1 = rs1; m_rs2 = rs2;
         end
         if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
      end
      @(posedge clk);
      #1;
      check_eq("ctrl", id_ex_ctrl, m_ctrl);
      check_eq("npc", id_ex_npc, m_npc);
      check_eq("a", id_ex_a, m_a);
      check_eq("b", id_ex_b, m_b);
      check_eq("imm", id_ex_imm, m_imm);
      check_eq("rd", id_ex_rd, m_rd);
      check_eq("rs1", id_ex_rs1, m_rs1);
      check_eq("rs2", id_ex_rs2, m_rs2);
      check_eq("illegal", illegal, m_illegal);
   endtask

   task automatic issue(input logic [31:0] inst, input logic [31:0] npc, input logic bc = 0,
                        input logic we = 0, input logic [4:0] wrd = 0,
                        input logic [31:0] wd = 0, input logic rst = 1);
      if_id[0] = inst; if_id[1] = npc; branch_cond = bc;
      wb_en = we; wb_rd = wrd; wb_data = wd; reset = rst;
      step();
   endtask

   function automatic logic [31:0] gen_inst();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 12))
         0: w[6:0] = 7'h37;
         1: w[6:0] = 7'h17;
         2: w[6:0] = 7'h6F;
         3: w[6:0] = 7'h67;
         4: w[6:0] = 7'h63;
         5, 6, 7: w[6:0] = 7'h03;
         8: w[6:0] = 7'h23;
         9: w[6:0] = 7'h13;
         10: w[6:0] = 7'h33;
         11: return 32'h0;
         default: ;
      endcase
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      w[11:7]  = 5'($urandom_range(0, 7));
      return w;
   endfunction

   logic [31:0] cur_inst, cur_npc;

   initial begin
      reset = 0; if_id = '0; branch_cond = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_eq("rst_ctrl", id_ex_ctrl, CTRL_NOP);
      check_eq("rst_illegal", illegal, 0);
      issue(32'h0, 32'h0);
      check_eq("t1_ctrl", id_ex_ctrl, CTRL_NOP);
      check_eq("t1_haz", s_haz, 0);

      issue(32'h0, 32'h0, 0, 1, 5'd5, 32'h1234);
      issue(32'hFFF28313, 32'h104);
      check_eq("t2_a", id_ex_a, 32'h1234);
      check_eq("t2_imm", id_ex_imm, 32'hFFFF_FFFF);
      check_eq("t2_rd", id_ex_rd, 6);
      check_eq("t2_srcimm", id_ex_ctrl.alu_src_imm, 1);

      issue(32'h0000A383, 32'h200);
      issue(32'h00238433, 32'h204);
      check_eq("t3_haz1", s_haz, 1);
      check_eq("t3_nop", id_ex_ctrl, CTRL_NOP);
      issue(32'h00238433, 32'h204);
      check_eq("t3_haz0", s_haz, 0);
      check_eq("t3_rs1", id_ex_rs1, 7);

      issue(32'h0000A003, 32'h300);
      issue(32'h00000433, 32'h304);
      check_eq("t4_haz", s_haz, 0);

      issue(32'h0000A383, 32'h400);
      issue(32'h00038463, 32'h404, 1);
      check_eq("t5_haz", s_haz, 0);
      check_eq("t5_nop", id_ex_ctrl, CTRL_NOP);
      check_eq("t5_illegal", illegal, 0);

      issue(32'h0031E233, 32'h500, 0, 1, 5'd3, 32'hDEAD);
      check_eq("t6_a", id_ex_a, 32'hDEAD);
      check_eq("t6_b", id_ex_b, 32'hDEAD);

      issue(32'h000004B3, 32'h600, 0, 1, 5'd0, 32'hFFFF);
      check_eq("x0_same", id_ex_a, 0);
      issue(32'h000004B3, 32'h604);
      check_eq("x0_after", id_ex_b, 0);

      issue(32'h0000007F, 32'h700);
      check_eq("ill_flag", illegal, 1);
      check_eq("ill_nop", id_ex_ctrl, CTRL_NOP);
      issue(32'h0000007F, 32'h704, 1);
      check_eq("ill_flushed", illegal, 0);

      // Reset arriving mid-stall clears everything.
      issue(32'h0000A383, 32'h800);
      issue(32'h00238433, 32'h804, 0, 0, 0, 0, 0);
      check_eq("rst_stall_haz", s_haz, 1);
      check_eq("rst_stall_ctrl", id_ex_ctrl, CTRL_NOP);
      issue(32'h00238433, 32'h804);
      check_eq("rst_stall_a", id_ex_a, 0);

      cur_inst = 0; cur_npc = 0;
      for (int k = 0; k < 800; k++) begin
         if (!m_haz) begin
            cur_inst = gen_inst();
            cur_npc  = $urandom;
         end
         issue(cur_inst, cur_npc, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 49) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
